muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the RISC-V datapath. It takes two source operands read from the register file (RD1/RD2) and the destination register index. It computes one of the eight M-extension operations over a fixed number of cycles, then presents the result with a one-cycle write strobe. That strobe drives the register file write port (WD3/A3/WE3). One operation is in flight at a time, and the core stalls while `busy` is high.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; one clock; reset is synchronous and active-low.
- start  input  1  request a new operation; accepted only on an edge where busy=0.
- funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  32  rs1 value (from RD1).
- op_b  input  32  rs2 value (from RD2).
- rd_in  input  5  destination register index.
- busy  output  1  high from the accept edge until the return to IDLE.
- done  output  1  one-cycle pulse; result/rd_out valid; drives WE3.
- result  output  32  operation result (to WD3).
- rd_out  output  5  latched rd_in (to A3).

## Operation
- **States:** IDLE, CALC, DONE.
- **IDLE, start=1:**
  - Latch funct3 and rd_in.
  - Convert signed operands to magnitudes: op_a for MULH/MULHSU/DIV/REM; op_b for MULH/DIV/REM. Record the result sign.
  - Clear the 64-bit accumulator and load the iteration counter with 0.
  - Go to CALC; busy=1.
- **CALC, one iteration per cycle, 32 iterations (counter 0..31):**
  - Multiply uses shift-add. Each step examines one multiplier bit and adds the multiplicand into the upper half.
  - Divide uses restoring division. Each step shifts the remainder/quotient pair left one bit, then trial-subtracts the divisor and keeps the result if it is non-negative.
  - After counter=31, go to DONE.
- **DONE:**
  - Apply sign correction (two's complement negate if the recorded sign is negative).
  - Drive result, done=1 and busy=1 for exactly one cycle, then go to IDLE.
- **Result selection:**
  - MUL: low 32 bits of the product.
  - MULH/MULHSU/MULHU: high 32 bits of the signed×signed, signed×unsigned and unsigned×unsigned product respectively.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - The remainder takes the sign of the dividend.
- **Special cases**, detected at accept and computed with the same fixed latency:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op_a unchanged.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV → 0x80000000; REM → 0.
- **Start while busy:** start=1 in CALC or DONE is ignored; no queueing and no effect on the in-flight operation.
- **Operand stability:** op_a, op_b and funct3 need only be valid on the accept edge.

## Timing
- **Reset:** rst_n=0 sampled on an edge sets state=IDLE, busy=0, done=0, result=0, rd_out=0, counter=0, accumulator=0.
- **Reset mid-operation:** the operation is aborted with no done pulse. busy=0 from the following cycle.
- **Latency:** accept at edge N. busy=1 after edge N. Iterations on edges N+1..N+32. DONE is entered at edge N+33, so done=1 during cycle N+33→N+34. IDLE is entered at edge N+34, and busy=0 from that point.
  - Total: 34 cycles from accept to the next possible accept edge.
- **Back-to-back:** earliest next accept is edge N+34.
- **Output holding:** done is never high for two consecutive cycles. result and rd_out hold their last values until the next DONE.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with start=1. Required: busy=0, done=0, result=0, rd_out=0, and no operation starts.
- **MUL and latency:** MUL 7×6 with rd_in=5. Required: result=0x0000002A, rd_out=5, done exactly 33 edges after the accept edge, and the done pulse is 1 cycle wide.
- **High-half multiplies:**
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- **Divides:**
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- **Corner cases:**
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- **Control:**
  - Pulse start with different operands during CALC: the in-flight result is unchanged.
  - Assert rst_n=0 at iteration 10: busy drops, no done pulse occurs, and a subsequent MUL 3×3 returns 9.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// Takes rs1/rs2 values and a destination index, runs one of the eight
// M-extension operations in a fixed 34-cycle slot, and presents the result
// with a one-cycle write strobe for the register file.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   synchronous active-low reset
//   start   request an operation; accepted only while busy=0
//   funct3  operation select (MUL..REMU)
//   op_a    rs1 value
//   op_b    rs2 value
//   rd_in   destination register index
//   busy    operation in flight
//   done    one-cycle result strobe (register file WE3)
//   result  operation result (WD3), held until the next done
//   rd_out  destination index (A3), held until the next done
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// CALC  | 32 shift-add / restoring-divide iterations, then one settle cycle
// DONE  | result and rd_out valid, done strobe high for one cycle

module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nxt;
    logic [5:0]        cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opa_q;     // multiplier (shifted right) or dividend (shifted left)
    logic [XLEN-1:0]   opb_q;     // multiplicand or divisor magnitude
    logic [2:0]        f_q;
    logic [4:0]        rd_q;
    logic              neg_q;

    // operand conditioning at accept
    logic            a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        a_neg    = a_signed & op_a[XLEN-1];
        b_neg    = b_signed & op_b[XLEN-1];
        a_mag    = a_neg ? -op_a : op_a;
        b_mag    = b_neg ? -op_b : op_b;
        case (funct3)
            3'b001:  neg_in = a_neg ^ b_neg;
            3'b010:  neg_in = a_neg;
            // A zero divisor must yield an all-ones quotient, so suppress negation.
            3'b100:  neg_in = (a_neg ^ b_neg) & (op_b != '0);
            3'b110:  neg_in = a_neg;
            default: neg_in = 1'b0;
        endcase
    end

    // one iteration step
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh, diff;
    logic              div_ok;
    logic [XLEN-1:0]   new_rem;
    logic [2*XLEN-1:0] acc_step;

    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (opa_q[0] ? {1'b0, opb_q} : '0);
        rem_sh  = {acc[2*XLEN-1:XLEN], opa_q[XLEN-1]};
        diff    = rem_sh - {1'b0, opb_q};
        div_ok  = ~diff[XLEN];
        new_rem = div_ok ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        if (f_q[2])
            acc_step = {new_rem, acc[XLEN-2:0], div_ok};
        else
            acc_step = {mul_sum, acc[XLEN-1:1]};
    end

    // sign correction and result selection
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res_c;

    always_comb begin
        prod = neg_q ? -acc : acc;
        case (f_q)
            3'b000:                 res_c = acc[XLEN-1:0];
            3'b001, 3'b010, 3'b011: res_c = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         res_c = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            default:                res_c = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == 6'(XLEN)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            f_q    <= '0;
            rd_q   <= '0;
            neg_q  <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        f_q   <= funct3;
                        rd_q  <= rd_in;
                        neg_q <= neg_in;
                        opa_q <= a_mag;
                        opb_q <= b_mag;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    if (cnt != 6'(XLEN)) begin
                        acc   <= acc_step;
                        opa_q <= f_q[2] ? {opa_q[XLEN-2:0], 1'b0} : {1'b0, opa_q[XLEN-1:1]};
                        cnt   <= cnt + 6'd1;
                    end else begin
                        result <= res_c;
                        rd_out <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd_in;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, p;
        longint unsigned up;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
            3'd3: begin up = {32'd0, a} * {32'd0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one operation and check latency, result, rd_out and strobe width.
    // With poke set, start is pulsed with unrelated operands mid-calculation.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit poke);
        int n;
        logic [31:0] exp;
        exp = ref_model(f, a, b);
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
        @(posedge clk); #1;
        start = 1'b0;
        funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd_in = 5'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 100) begin
            start = poke && (n == 5);
            @(posedge clk); #1;
            start = 1'b0;
            op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
            n++;
        end
        check("latency", 32'(n), 32'd33);
        check($sformatf("result f=%0d a=%08h b=%08h", f, a, b), result, exp);
        check("rd_out", 32'(rd_out), 32'(rd));
        @(posedge clk); #1;
        check("done_width", 32'(done), 32'd0);
        check("busy_release", 32'(busy), 32'd0);
        check("result_hold", result, exp);
    endtask

    initial begin
        int k;
        logic [31:0] ra, rb;
        logic [31:0] corner [4];
        corner[0] = 32'h0; corner[1] = 32'hFFFFFFFF; corner[2] = 32'h80000000; corner[3] = 32'h1;

        rst_n = 1'b0; start = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; rd_in = 5'd9;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_no_start", 32'(busy), 32'd0);

        do_op(3'd0, 32'd7, 32'd6, 5'd5, 0);
        check("mul_7x6", result, 32'h0000002A);
        do_op(3'd1, 32'h80000000, 32'h80000000, 5'd1, 0);
        check("mulh", result, 32'h40000000);
        do_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 0);
        check("mulhu", result, 32'hFFFFFFFE);
        do_op(3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd3, 0);
        check("mulhsu", result, 32'hFFFFFFFF);
        do_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, 0);
        check("div_m7_2", result, 32'hFFFFFFFD);
        do_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd6, 0);
        check("rem_m7_2", result, 32'hFFFFFFFF);
        do_op(3'd5, 32'd100, 32'd7, 5'd7, 0);
        check("divu_100_7", result, 32'd14);
        do_op(3'd7, 32'd100, 32'd7, 5'd8, 0);
        check("remu_100_7", result, 32'd2);
        do_op(3'd4, 32'd5, 32'd0, 5'd10, 0);
        check("div_by0", result, 32'hFFFFFFFF);
        do_op(3'd6, 32'd5, 32'd0, 5'd11, 0);
        check("rem_by0", result, 32'd5);
        do_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 0);
        check("div_ovf", result, 32'h80000000);
        do_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 0);
        check("rem_ovf", result, 32'd0);

        do_op(3'd0, 32'd1234, 32'd5678, 5'd14, 1);
        check("start_while_busy", result, 32'd7006652);

        // reset during iteration 10
        @(negedge clk);
        start = 1'b1; funct3 = 3'd0; op_a = 32'd11; op_b = 32'd13; rd_in = 5'd15;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) k++;
        end
        check("abort_no_done", 32'(k), 32'd0);
        do_op(3'd0, 32'd3, 32'd3, 5'd16, 0);
        check("mul_after_abort", result, 32'd9);

        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
            do_op(3'($urandom), ra, rb, 5'($urandom), ($urandom_range(0, 7) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
